dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter sharing the single-port data memory between the CPU data port (M0) and the preload/dump DMA (M1). It sits between both masters and the slow data memory, using the same word-address / wen / 32-bit data convention as the memory interface. It serialises accesses with round-robin fairness and stalls the losing master. It also counts contention cycles for cycle-budget analysis alongside the testbed `duration` report.

## Interface
- ADDR_W, 30, word-address width (byte address >> 2)
- DATA_W, 32, data width (little-endian byte order, passed through untouched)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- m0_ren, m0_wen  in  1  M0 read / write request, held until stall drops
- m0_addr  in  ADDR_W  M0 word address
- m0_wdata  in  DATA_W  M0 write data
- m0_rdata  out  DATA_W  M0 read data, valid in M0 response cycle
- m0_stall  out  1  M0 must hold request while high
- m1_ren, m1_wen, m1_addr, m1_wdata, m1_rdata, m1_stall  same as M0, for M1
- s_ren, s_wen  out  1  memory read / write strobe, registered
- s_addr  out  ADDR_W, s_wdata  out  DATA_W  registered memory address / write data
- s_rdata  in  DATA_W  memory read data, valid with s_ready
- s_ready  in  1  memory completion, one cycle per access (reads and writes)
- conflict_cnt  out  16  saturating count of cycles with both masters requesting in IDLE

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Sample requests. If none, stay.
  - Else pick grantee `gnt`:
    - single requester wins;
    - if both request, the master != `last_gnt` wins.
  - Latch op/addr/wdata into s_* registers, update `last_gnt`, go to BUSY.
- BUSY:
  - Hold s_ren/s_wen/s_addr/s_wdata stable.
  - On s_ready: capture s_rdata into grantee's rdata register (reads only), clear s_ren/s_wen, go to RESP.
- RESP: one cycle, then always IDLE.
- mX_stall = (mX_ren | mX_wen) & ~(state==RESP & gnt==X). Combinational, so a request stalls in its first cycle.
- ren and wen both high from one master: treated as a write.
- Request dropped before grant: ignored, since requests are only sampled in IDLE.
- Request dropped during BUSY: memory access completes, response discarded, no error.
- Non-grantee mX_rdata holds its previous value.
- conflict_cnt: +1 per IDLE cycle with both masters requesting; sticks at 16'hFFFF.

## Timing
- Reset (rst low at a rising edge):
  - state=IDLE, last_gnt=M1 (so M0 wins the first tie);
  - s_ren=s_wen=0, s_addr=0, s_wdata=0;
  - m0_rdata=m1_rdata=0, conflict_cnt=0.
- Reset mid-BUSY aborts the access: s_* low after that edge, no response delivered.
- Request first seen in IDLE at cycle 0:
  - s_* valid from cycle 1;
  - earliest s_ready in cycle 1;
  - RESP (stall low, rdata valid) in cycle 2.
- Minimum occupancy is 3 cycles per access. With memory latency k cycles (s_ready in cycle k), RESP is in cycle k+1.
- Back-to-back: a master may re-request in the cycle after RESP, which is IDLE.
- s_ready is ignored in IDLE and RESP.
- Worst-case wait for a requester: one full foreign access plus its own.

## Structure
- Package dmem_pkg holds:
  - ADDR_W / DATA_W defaults;
  - state enum {IDLE, BUSY, RESP};
  - master index constants M0=0, M1=1.
- One sub-module, rr_arb2: a 2-way round-robin picker.
  - Inputs: req[1:0], last_gnt.
  - Output: combinational gnt index and a valid flag.
  - The last_gnt register stays in dmem_arbiter.

## Test plan
- M0 read addr 30'd128, memory returns 32'h11223344 with s_ready in cycle 1 -> s_ren high cycle 1 only, m0_stall low in cycle 2 only, m0_rdata=32'h11223344.
- M1 write addr 30'd255 data 32'hDEADBEEF, s_ready after 4 cycles -> s_wen/s_addr/s_wdata stable 4 cycles, m1_stall drops one cycle later, m1_rdata unchanged.
- Both request continuously after reset -> grant order M0,M1,M0,M1; conflict_cnt increments once per IDLE tie.
- Same master asserts ren and wen together -> memory sees a write only.
- rst low during BUSY with s_ready withheld -> all s_* zero next cycle, FSM IDLE, no RESP, conflict_cnt=0.
- Force 70000 tie cycles -> conflict_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, FSM states and master indices for the data-memory arbiter
package dmem_pkg;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; on a tie the master that did not win last wins
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt,
    output logic       valid
);
    assign valid = |req;
    assign gnt   = &req ? ~last_gnt : req[M1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU (M0) and DMA (M1) accesses onto the single-port data memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_ren,
    input  logic              m0_wen,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_stall,
    input  logic              m1_ren,
    input  logic              m1_wen,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_stall,
    output logic              s_ren,
    output logic              s_wen,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    output logic [15:0]       conflict_cnt
);
    state_t state, state_n;
    logic last_gnt, last_gnt_n, gnt, gnt_valid, cap;
    logic [1:0] req;
    logic s_ren_n, s_wen_n;
    logic [ADDR_W-1:0] s_addr_n;
    logic [DATA_W-1:0] s_wdata_n, m0_rdata_n, m1_rdata_n;
    logic [15:0] cnt, cnt_n;

    assign req          = {m1_ren | m1_wen, m0_ren | m0_wen};
    assign m0_stall     = req[M0] & ~(state == RESP & last_gnt == M0);
    assign m1_stall     = req[M1] & ~(state == RESP & last_gnt == M1);
    assign conflict_cnt = cnt;

    rr_arb2 u_arb (.req(req), .last_gnt(last_gnt), .gnt(gnt), .valid(gnt_valid));

    // last_gnt doubles as the grantee index while BUSY/RESP
    always_comb begin
        state_n    = state;
        last_gnt_n = last_gnt;
        s_ren_n    = s_ren;
        s_wen_n    = s_wen;
        s_addr_n   = s_addr;
        s_wdata_n  = s_wdata;
        cap        = 1'b0;
        case (state)
            IDLE: if (gnt_valid) begin
                state_n    = BUSY;
                last_gnt_n = gnt;
                s_wen_n    = gnt ? m1_wen : m0_wen;
                s_ren_n    = gnt ? m1_ren & ~m1_wen : m0_ren & ~m0_wen;
                s_addr_n   = gnt ? m1_addr : m0_addr;
                s_wdata_n  = gnt ? m1_wdata : m0_wdata;
            end
            BUSY: if (s_ready) begin
                state_n = RESP;
                s_ren_n = 1'b0;
                s_wen_n = 1'b0;
                cap     = s_ren;
            end
            default: state_n = IDLE;
        endcase
        m0_rdata_n = cap && last_gnt == M0 ? s_rdata : m0_rdata;
        m1_rdata_n = cap && last_gnt == M1 ? s_rdata : m1_rdata;
        cnt_n      = state == IDLE && &req && ~&cnt ? cnt + 16'd1 : cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            last_gnt <= M1;
            s_ren    <= 1'b0;
            s_wen    <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            last_gnt <= last_gnt_n;
            s_ren    <= s_ren_n;
            s_wen    <= s_wen_n;
            s_addr   <= s_addr_n;
            s_wdata  <= s_wdata_n;
            m0_rdata <= m0_rdata_n;
            m1_rdata <= m1_rdata_n;
            cnt      <= cnt_n;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
    logic clk, rst;
    logic m0_ren, m0_wen, m1_ren, m1_wen, m0_stall, m1_stall;
    logic [29:0] m0_addr, m1_addr, s_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic s_ren, s_wen, s_ready;
    logic [15:0] conflict_cnt;
    int n_tests = 0, n_fail = 0;
    bit auto_mem = 0;
    int fix_lat = 0, cyc = 0, lat = 1;
    logic [31:0] mem [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_stall(m0_stall),
        .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_stall(m1_stall),
        .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .conflict_cnt(conflict_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // memory stub: answers each access after 1..4 cycles when auto_mem is set
    initial forever begin
        @(posedge clk); #1;
        if (auto_mem && (s_ren || s_wen)) begin
            if (cyc == 0) lat = fix_lat != 0 ? fix_lat : int'($urandom_range(1, 4));
            cyc++;
            s_ready = cyc == lat;
            s_rdata = (cyc == lat && s_ren) ? (mem.exists(s_addr) ? mem[s_addr] : init_word(s_addr)) : $urandom;
            if (cyc == lat && s_wen) mem[s_addr] = s_wdata;
        end else begin
            cyc = 0;
            if (auto_mem) s_ready = 1'b0;
        end
    end

    task automatic set_req(input bit m, input logic ren, input logic wen, input logic [29:0] a, input logic [31:0] d);
        if (m) begin m1_ren = ren; m1_wen = wen; m1_addr = a; m1_wdata = d; end
        else begin m0_ren = ren; m0_wen = wen; m0_addr = a; m0_wdata = d; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0; s_ready = 0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({s_ren, s_wen, s_addr, s_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_s: got ren=%b wen=%b addr=%h wdata=%h, want all 0", s_ren, s_wen, s_addr, s_wdata);
        end
        n_tests++;
        if ({m0_rdata, m1_rdata, conflict_cnt, m0_stall, m1_stall} !== '0) begin
            n_fail++; $display("FAIL reset_regs: got rd0=%h rd1=%h cnt=%h st=%b%b, want 0", m0_rdata, m1_rdata, conflict_cnt, m0_stall, m1_stall);
        end
    endtask

    task automatic test_m0_read();
        @(posedge clk); #1; set_req(0, 1, 0, 30'd128, 0);
        @(negedge clk);
        n_tests++;
        if ({m0_stall, s_ren} !== 2'b10) begin
            n_fail++; $display("FAIL rd_c0: got stall=%b s_ren=%b, want 1 0", m0_stall, s_ren);
        end
        @(posedge clk); #1; s_ready = 1; s_rdata = 32'h11223344;
        @(negedge clk);
        n_tests++;
        if ({s_ren, s_wen, s_addr, m0_stall} !== {2'b10, 30'd128, 1'b1}) begin
            n_fail++; $display("FAIL rd_c1: got ren=%b wen=%b addr=%0d stall=%b, want 1 0 128 1", s_ren, s_wen, s_addr, m0_stall);
        end
        @(posedge clk); #1; s_ready = 0; s_rdata = 32'hFFFF0000;
        @(negedge clk);
        n_tests++;
        if ({m0_stall, s_ren, m0_rdata} !== {2'b00, 32'h11223344}) begin
            n_fail++; $display("FAIL rd_c2: got stall=%b s_ren=%b rdata=%h, want 0 0 11223344", m0_stall, s_ren, m0_rdata);
        end
        @(posedge clk); #1; set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if ({s_ren, m0_rdata} !== {1'b0, 32'h11223344}) begin
            n_fail++; $display("FAIL rd_c3: got s_ren=%b rdata=%h, want 0 11223344", s_ren, m0_rdata);
        end
    endtask

    task automatic test_m1_write();
        @(posedge clk); #1; set_req(1, 0, 1, 30'd255, 32'hDEADBEEF);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            s_ready = c == 4; s_rdata = 32'hBAD0BAD0;
            @(negedge clk);
            n_tests++;
            if ({s_wen, s_ren, s_addr, s_wdata, m1_stall} !== {2'b10, 30'd255, 32'hDEADBEEF, 1'b1}) begin
                n_fail++; $display("FAIL wr_c%0d: got wen=%b ren=%b addr=%0d wdata=%h stall=%b", c, s_wen, s_ren, s_addr, s_wdata, m1_stall);
            end
        end
        @(posedge clk); #1; s_ready = 0;
        @(negedge clk);
        n_tests++;
        if ({m1_stall, s_wen, m1_rdata} !== {2'b00, 32'h0}) begin
            n_fail++; $display("FAIL wr_c5: got stall=%b s_wen=%b rdata=%h, want 0 0 00000000", m1_stall, s_wen, m1_rdata);
        end
        @(posedge clk); #1; set_req(1, 0, 0, 0, 0);
    endtask

    task automatic test_ren_wen();
        @(posedge clk); #1; set_req(0, 1, 1, 30'd7, 32'h0BADCAFE);
        @(posedge clk); #1; s_ready = 1; s_rdata = 32'h99999999;
        @(negedge clk);
        n_tests++;
        if ({s_wen, s_ren, s_addr, s_wdata} !== {2'b10, 30'd7, 32'h0BADCAFE}) begin
            n_fail++; $display("FAIL renwen_op: got wen=%b ren=%b addr=%0d wdata=%h, want write 7 0badcafe", s_wen, s_ren, s_addr, s_wdata);
        end
        @(posedge clk); #1; s_ready = 0;
        @(negedge clk);
        n_tests++;
        if ({m0_stall, m0_rdata} !== {1'b0, 32'h11223344}) begin
            n_fail++; $display("FAIL renwen_resp: got stall=%b rdata=%h, want 0 11223344", m0_stall, m0_rdata);
        end
        @(posedge clk); #1; set_req(0, 0, 0, 0, 0);
    endtask

    task automatic test_round_robin();
        do_reset();
        auto_mem = 1; fix_lat = 1;
        set_req(0, 1, 0, 30'd1, 0);
        set_req(1, 1, 0, 30'd65, 0);
        for (int g = 0; g < 4; g++) begin
            int t = 0;
            do begin @(negedge clk); t++; end while (m0_stall && m1_stall && t < 20);
            n_tests++;
            if ({m0_stall, m1_stall} !== (g % 2 == 0 ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL rr_grant%0d: got stalls=%b%b, want %s", g, m0_stall, m1_stall, g % 2 == 0 ? "M0" : "M1");
            end
            n_tests++;
            if (conflict_cnt !== 16'(g + 1)) begin
                n_fail++; $display("FAIL rr_cnt%0d: got %0d, want %0d", g, conflict_cnt, g + 1);
            end
        end
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
        auto_mem = 0; fix_lat = 0; s_ready = 0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_busy();
        @(posedge clk); #1;
        set_req(0, 1, 0, 30'd3, 0); set_req(1, 1, 0, 30'd67, 0);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (s_ren !== 1'b1 || conflict_cnt === 16'd0) begin
            n_fail++; $display("FAIL rstbusy_pre: got s_ren=%b cnt=%0d, want 1 and nonzero", s_ren, conflict_cnt);
        end
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({s_ren, s_wen, s_addr, s_wdata, conflict_cnt, m0_rdata, m1_rdata} !== '0 || {m0_stall, m1_stall} !== 2'b11) begin
            n_fail++; $display("FAIL rstbusy: got ren=%b wen=%b addr=%h cnt=%0d st=%b%b, want s_* 0 cnt 0 stalls 11", s_ren, s_wen, s_addr, conflict_cnt, m0_stall, m1_stall);
        end
        @(posedge clk); #1; rst = 1;
        set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if ({m0_stall, m1_stall, s_ren} !== 3'b000) begin
            n_fail++; $display("FAIL rstbusy_idle: got st=%b%b s_ren=%b, want 000", m0_stall, m1_stall, s_ren);
        end
    endtask

    task automatic master_run(input bit m, input int n);
        for (int i = 0; i < n; i++) begin
            logic wr = 1'($urandom_range(0, 1));
            logic [29:0] a = 30'(m * 64 + $urandom_range(0, 15));
            logic [31:0] d = $urandom;
            logic [31:0] exp;
            int t = 0;
            @(posedge clk); #1;
            set_req(m, 0, 0, 0, 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            set_req(m, ~wr, wr, a, d);
            do begin @(negedge clk); t++; end while ((m ? m1_stall : m0_stall) && t < 30);
            n_tests++;
            if ((m ? m1_stall : m0_stall) !== 1'b0 || t - 1 > 11) begin
                n_fail++; $display("FAIL rand_wait m%0d: stall=%b after %0d stalled cycles, want 0 within 11", m, m ? m1_stall : m0_stall, t - 1);
            end
            if (wr) ref_mem[a] = d;
            else begin
                exp = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
                n_tests++;
                if ((m ? m1_rdata : m0_rdata) !== exp) begin
                    n_fail++; $display("FAIL rand_rd m%0d addr %0d: got %h, want %h", m, a, m ? m1_rdata : m0_rdata, exp);
                end
            end
        end
        @(posedge clk); #1; set_req(m, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        auto_mem = 1; fix_lat = 0;
        fork
            master_run(0, 40);
            master_run(1, 40);
        join
        repeat (3) @(posedge clk);
    endtask

    // counter preloaded near the top instead of spending ~200k cycles on real ties
    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        force dut.cnt = 16'hFFFC;
        #1 release dut.cnt;
        #1;
        n_tests++;
        if (conflict_cnt !== 16'hFFFC) begin
            n_fail++; $display("FAIL sat_preload: got %h, want fffc", conflict_cnt);
        end
        auto_mem = 1; fix_lat = 1;
        @(posedge clk); #1;
        set_req(0, 1, 0, 30'd2, 0); set_req(1, 1, 0, 30'd66, 0);
        for (int g = 0; g < 6; g++) begin
            int t = 0;
            int e = 65532 + g + 1;
            do begin @(negedge clk); t++; end while (m0_stall && m1_stall && t < 20);
            e = e > 65535 ? 65535 : e;
            n_tests++;
            if (conflict_cnt !== 16'(e) || t >= 20) begin
                n_fail++; $display("FAIL sat_cnt%0d: got %h, want %h", g, conflict_cnt, 16'(e));
            end
        end
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
        auto_mem = 0; fix_lat = 0;
    endtask

    initial begin
        rst = 0; s_ready = 0; s_rdata = 0;
        m0_ren = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0;
        m1_ren = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0;
        test_reset();
        test_m0_read();
        test_m1_write();
        test_ren_wen();
        test_round_robin();
        test_reset_busy();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule
